trace_capture_buffer: RTL
=========================

# trace_capture_buffer

- Synthesizable, parametrised instruction-trace recorder that sits beside the processor `top`.
- Each cycle with a retired instruction, it records PC, instruction word and the data-memory write into a circular buffer.
- A PC-match trigger plus a post-trigger count freezes the buffer so its history can be read out through a simple request/response port.
- It replaces ad-hoc waveform inspection of the fetch and dmem signals with an on-chip, self-contained capture.

## Interface
Parameters:
- `PC_W`, 5: instruction address width
- `INST_W`, 16: instruction word width
- `DADDR_W`, 4: data-memory address width
- `DATA_W`, 8: data-memory data width
- `DEPTH`, 16: entries; power of two, ≥ 2
- `POST_TRIG`, 4: entries captured after the trigger entry; 0 ≤ `POST_TRIG` < `DEPTH`

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low (0 = reset)
- `in_valid` in 1: one instruction retires this cycle
- `in_pc` in `PC_W`: PC of the retiring instruction
- `in_inst` in `INST_W`: instruction word
- `in_dmem_we` in 1: instruction wrote dmem
- `in_dmem_addr` in `DADDR_W`: dmem write address
- `in_dmem_data` in `DATA_W`: dmem write data
- `arm` in 1: clear buffer and start capturing
- `abort` in 1: force freeze
- `trig_pc` in `PC_W`: trigger PC
- `rd_en` in 1: read request
- `rd_idx` in `$clog2(DEPTH)`: read index, 0 = oldest entry
- `state` out 2: current FSM state
- `count` out `$clog2(DEPTH)+1`: valid entries
- `trig_seen` out 1: trigger has fired since the last `arm`
- `rd_valid` out 1: read response strobe
- `rd_oob` out 1: `rd_idx` ≥ `count`
- `rd_pc`, `rd_inst`, `rd_we`, `rd_daddr`, `rd_ddata` out: entry fields

## Operation
- States: `IDLE`=0, `ARMED`=1, `POST`=2, `FROZEN`=3.
- Capture happens only in `ARMED` and `POST` on `in_valid`:
  - The entry is written at `wr_ptr`, and `wr_ptr` increments modulo `DEPTH`.
  - `count` saturates at `DEPTH`; once full, the oldest entry is overwritten.
- State transitions:
  - `IDLE`/`FROZEN` + `arm` → `ARMED`, with `count`=0, `wr_ptr`=0, `trig_seen`=0. `arm` is ignored in `ARMED`/`POST`.
  - `ARMED` + `in_valid` + `in_pc`==`trig_pc`: the entry is captured and `trig_seen` is set. Next state is `POST` with `post_cnt`=`POST_TRIG`, or `FROZEN` directly if `POST_TRIG`==0.
  - In `POST`, each captured entry decrements `post_cnt`. The entry that takes it to 0 is captured, and the next state is `FROZEN`.
  - `abort` in `ARMED`/`POST` → `FROZEN`. The same-cycle entry is not captured. `abort` beats trigger, and `trig_seen` is unchanged.
- Readout, in `FROZEN` only:
  - Physical index = (`wr_ptr` − `count` + `rd_idx`) mod `DEPTH`.
  - If `rd_idx` ≥ `count`: `rd_oob`=1 and all data fields are 0.
  - `rd_en` in any other state is ignored: `rd_valid` stays 0.
- Storage is not cleared by `arm`. Stale data is never visible because of the `count`/`rd_oob` gating.

## Timing
- Reset values: `state`=`IDLE`, `count`=0, `trig_seen`=0, `rd_valid`=0, `rd_oob`=0, all `rd_*` fields 0. Pointers are 0.
- Reset takes effect immediately and asynchronously, including mid-capture or mid-readout.
- Capture latency: an entry presented on cycle N is visible in `count` after edge N.
- Freeze timing: `state`=`FROZEN` is visible after the edge that captured the last post-trigger entry.
- Read latency is 1 cycle: `rd_en` sampled at edge N gives `rd_valid`=1 with fields held stable for exactly cycle N+1. The fields return to 0 when `rd_valid`=0. Back-to-back reads are allowed every cycle.
- `arm` and `rd_en` in the same `FROZEN` cycle: the read completes with the pre-arm data, and `state` becomes `ARMED`.

## Structure
- Package `trace_pkg`:
  - `state_e` enum for the four states.
  - `trace_entry_t` packed struct (pc, inst, we, daddr, ddata), parameterised via package-level default widths matching the processor (5/16/4/8).
- Sub-module `trace_ram`: a `DEPTH`×entry synchronous-write, registered-read dual-port array.
- The top-level module holds the FSM, pointers, `post_cnt` and the index mapping.

## Test plan
- **Reset mid-capture:** with defaults, arm, feed 3 entries, pull `reset` low asynchronously mid-cycle. Outputs return to reset values immediately; after release, `rd_en` is ignored.
- **Wrap-around:** arm with `trig_pc`=5'h1F (never hit), feed 20 entries with PC 0..19, then `abort`. Result: `state`=3, `count`=16, `trig_seen`=0; reading idx 0 gives PC 4, idx 15 gives PC 19.
- **Post-trigger freeze:** arm with `trig_pc`=6, feed PCs 0..15 each cycle. Freeze happens after PC 10; `count`=11, idx 6 gives PC 6, idx 10 gives PC 10, and PCs 11+ are not captured.
- **Zero post-trigger:** `POST_TRIG`=0, `trig_pc`=2, PCs 0..5. Freeze happens after PC 2; `count`=3.
- **Out-of-range read:** with `count`=3, `rd_idx`=7 gives, next cycle, `rd_valid`=1, `rd_oob`=1, fields 0.
- **Abort-versus-trigger collision:** `abort` and the trigger-matching `in_valid` arrive in the same cycle. The entry is not captured, `trig_seen`=0, `state`=`FROZEN`.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the instruction-trace capture buffer: FSM state encoding and
// the default-width trace entry layout that matches the processor.
package trace_pkg;

  localparam int PC_W_DEF    = 5;
  localparam int INST_W_DEF  = 16;
  localparam int DADDR_W_DEF = 4;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } state_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INST_W_DEF-1:0]  inst;
    logic                   we;
    logic [DADDR_W_DEF-1:0] daddr;
    logic [DATA_W_DEF-1:0]  ddata;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// DEPTH x WIDTH storage for trace entries: synchronous write port and a
// separate read port whose data is registered on a read enable.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The array itself is never reset; stale contents are hidden by the owner.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_capture_buffer.sv
// Instruction-trace recorder: captures retired instructions into a circular
// buffer, freezes on a PC trigger (plus post-trigger entries) or abort, then
// serves the frozen history through a one-cycle-latency read port.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter int INST_W    = 16,
  parameter int DADDR_W   = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  input  logic                       in_dmem_we,
  input  logic [DADDR_W-1:0]         in_dmem_addr,
  input  logic [DATA_W-1:0]          in_dmem_data,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [PC_W-1:0]            trig_pc,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       trig_seen,
  output logic                       rd_valid,
  output logic                       rd_oob,
  output logic [PC_W-1:0]            rd_pc,
  output logic [INST_W-1:0]          rd_inst,
  output logic                       rd_we,
  output logic [DADDR_W-1:0]         rd_daddr,
  output logic [DATA_W-1:0]          rd_ddata
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = PC_W + INST_W + 1 + DADDR_W + DATA_W;

  state_e          state_q, state_next;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   post_cnt;
  logic            trig_seen_q;
  logic            rd_valid_q, rd_oob_q;

  logic            capture, trig_hit, post_done, arm_ok, rd_fire;
  logic [AW-1:0]   rd_phys;
  logic            idx_oob;
  logic [ENTRY_W-1:0] wdata, rdata;

  // Read port handshake: rd_en is a one-cycle request; rd_valid answers it
  // exactly one cycle later and never back-pressures.

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_next;
  end

  // Next-state logic; abort outranks a same-cycle trigger.
  always_comb begin
    state_next = state_q;
    unique case (state_q)
      IDLE:   if (arm) state_next = ARMED;
      ARMED: begin
        if (abort)         state_next = FROZEN;
        else if (trig_hit) state_next = (POST_TRIG == 0) ? FROZEN : POST;
      end
      POST: begin
        if (abort)          state_next = FROZEN;
        else if (post_done) state_next = FROZEN;
      end
      FROZEN: if (arm) state_next = ARMED;
      default: state_next = IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    capture   = 1'b0;
    trig_hit  = 1'b0;
    post_done = 1'b0;
    arm_ok    = 1'b0;
    rd_fire   = 1'b0;
    unique case (state_q)
      IDLE:   arm_ok = arm;
      ARMED: begin
        capture  = in_valid && !abort;
        trig_hit = capture && (in_pc == trig_pc);
      end
      POST: begin
        capture   = in_valid && !abort;
        post_done = capture && (post_cnt == AW'(1));
      end
      FROZEN: begin
        arm_ok  = arm;
        rd_fire = rd_en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      count_q     <= '0;
      post_cnt    <= '0;
      trig_seen_q <= 1'b0;
    end else if (arm_ok) begin
      wr_ptr      <= '0;
      count_q     <= '0;
      post_cnt    <= '0;
      trig_seen_q <= 1'b0;
    end else if (capture) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (count_q != CW'(DEPTH)) count_q <= count_q + CW'(1);
      if (trig_hit) begin
        post_cnt    <= AW'(POST_TRIG);
        trig_seen_q <= 1'b1;
      end else if (state_q == POST) begin
        post_cnt <= post_cnt - AW'(1);
      end
    end
  end

  // Logical index 0 is the oldest entry; when full, wr_ptr points at it.
  assign rd_phys = wr_ptr - count_q[AW-1:0] + rd_idx;
  assign idx_oob = {1'b0, rd_idx} >= count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      rd_oob_q   <= rd_fire && idx_oob;
    end
  end

  assign wdata = {in_pc, in_inst, in_dmem_we, in_dmem_addr, in_dmem_data};

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (rd_fire),
    .raddr (rd_phys),
    .rdata (rdata)
  );

  assign state     = state_q;
  assign count     = count_q;
  assign trig_seen = trig_seen_q;
  assign rd_valid  = rd_valid_q;
  assign rd_oob    = rd_oob_q;

  // Fields read as zero outside the response cycle and for out-of-range reads.
  assign {rd_pc, rd_inst, rd_we, rd_daddr, rd_ddata} =
    (rd_valid_q && !rd_oob_q) ? rdata : '0;

endmodule
